ps2_rx_fifo: RTL and testbench

Parametrised PS/2 receive engine, the successor to the single-byte PS/2 comm block.
- Deglitches PS2_CLK and deframes 11-bit device-to-host frames, checking start, odd parity and stop.
- Buffers received bytes in a show-ahead FIFO with a ready/valid consumer interface.
- Drives a configurable run of active-low 7-segment digits showing the most recent bytes.
- Sits between the board PS/2 pins and user logic (keyboard/mouse decoders) in Top.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_sync_fifo.sv | 72 +++++++
 rtl/ps2_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 receive types, frame constants and the
//               active-low 7-segment glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int unsigned c_DATA_BITS     = 8;
    localparam int unsigned c_FRAME_BITS    = 11;
    localparam logic        c_START_BIT     = 1'b0;
    localparam logic        c_STOP_BIT      = 1'b1;
    localparam logic [2:0]  c_LAST_DATA_IDX = 3'(c_DATA_BITS - 1);

    localparam logic [6:0]  c_SEG_BLANK = 7'h7F;

    // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0, segments {g,f,e,d,c,b,a}
    localparam logic [15:0][6:0] c_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return c_SEG_TABLE[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_fifo
// Description : Show-ahead synchronous FIFO; a push into a full FIFO is
//               accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_accept,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]      c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_pop;
    logic w_push_ok;

    assign w_pop     = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != c_FULL) || w_pop);

    assign o_accept = w_push_ok;
    assign o_data   = r_mem[r_rd_ptr];
    assign o_valid  = (r_count != '0);
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver with clock deglitch, frame check,
//               show-ahead byte FIFO and 7-segment history. Optional macro
//               PS2_ERR_KEEP_EN keeps bad frames tagged on rx_err.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int HIST           = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    inout  wire                           PS2_CLK,
    inout  wire                           PS2_DAT,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          frame_err,
`ifdef PS2_ERR_KEEP_EN
    output logic                          rx_err,
`endif
    output logic [14*HIST-1:0]            HEX
);

`ifdef PS2_ERR_KEEP_EN
    localparam int c_FIFO_W = 9;
`else
    localparam int c_FIFO_W = 8;
`endif
    localparam int                  c_FLT_W    = $clog2(FILTER_LEN + 1);
    localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FLT_W-1:0]  c_FLT_LAST = c_FLT_W'(FILTER_LEN - 1);
    localparam logic [c_FLT_W-1:0]  c_FLT_ONE  = c_FLT_W'(1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE  = c_TMO_W'(1);

    // The pins are open-collector inputs here; the host never drives them
    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic                r_clk_filt;
    logic [c_FLT_W-1:0]  r_flt_cnt;
    rx_state_t           r_state;
    rx_state_t           w_state_nxt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                r_frame_err;
    logic                r_overflow;
    logic [7:0]          r_hist [HIST];
    logic [HIST-1:0]     r_hist_vld;

    logic                w_fall;
    logic                w_dat;
    logic                w_timeout;
    logic                w_stop_eval;
    logic                w_frame_good;
    logic                w_push;
    logic [c_FIFO_W-1:0] w_push_data;
    logic                w_accept;
    logic [c_FIFO_W-1:0] w_head;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + c_FLT_ONE;
            end
        end
    end

    // Edge is flagged on the cycle the filter commits the 1 -> 0 change
    assign w_fall    = r_clk_filt && !r_clk_sync[1] && (r_flt_cnt == c_FLT_LAST);
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stop_eval = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (w_dat == c_START_BIT) w_state_nxt = DATA;
                DATA:    if (r_bit_idx == c_LAST_DATA_IDX) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    w_stop_eval = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bit_idx <= '0;
                    DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    PARITY: r_parity <= w_dat;
                    default: ;
                endcase
            end
            if ((r_state == IDLE) || w_fall) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end
        end
    end

    // Odd parity over data+parity, and the stop bit sampled live on its edge
    assign w_frame_good = (^{r_shift, r_parity}) && (w_dat == c_STOP_BIT);

`ifdef PS2_ERR_KEEP_EN
    assign w_push      = w_stop_eval;
    assign w_push_data = {!w_frame_good, r_shift};
    assign rx_err      = w_head[8];
`else
    assign w_push      = w_stop_eval && w_frame_good;
    assign w_push_data = r_shift;
`endif

    ps2_sync_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst      (reset),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .o_accept (w_accept),
        .i_pop    (rx_ready),
        .o_data   (w_head),
        .o_valid  (rx_valid),
        .o_count  (fifo_count)
    );

    assign rx_data = w_head[7:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_timeout || (w_stop_eval && !w_frame_good);
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hist_vld <= '0;
            for (int k = 0; k < HIST; k++) begin
                r_hist[k] <= '0;
            end
        end else if (w_accept) begin
            r_hist[0]     <= w_push_data[7:0];
            r_hist_vld[0] <= 1'b1;
            for (int k = 1; k < HIST; k++) begin
                r_hist[k]     <= r_hist[k-1];
                r_hist_vld[k] <= r_hist_vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < HIST; k++) begin : g_hex
        assign HEX[14*k +: 7]   = r_hist_vld[k] ? hex_to_seg(r_hist[k][3:0]) : c_SEG_BLANK;
        assign HEX[14*k+7 +: 7] = r_hist_vld[k] ? hex_to_seg(r_hist[k][7:4]) : c_SEG_BLANK;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Scoreboard bench for ps2_rx_fifo using a shortened PS/2 bit
//               period and a reduced frame timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int c_FIFO_DEPTH = 16;
    localparam int c_FILTER_LEN = 8;
    localparam int c_TIMEOUT    = 1000;
    localparam int c_HIST       = 2;
    localparam int c_HALF_BIT   = 25;
    localparam int c_CW         = $clog2(c_FIFO_DEPTH) + 1;

    logic r_clk          = 1'b0;
    logic r_rst          = 1'b1;
    logic r_rx_ready     = 1'b0;
    logic r_clr_overflow = 1'b0;
    logic r_ps2_clk      = 1'b1;
    logic r_ps2_dat      = 1'b1;

    wire w_ps2_clk;
    wire w_ps2_dat;
    assign w_ps2_clk = r_ps2_clk;
    assign w_ps2_dat = r_ps2_dat;

    logic [7:0]          w_rx_data;
    logic                w_rx_valid;
    logic [c_CW-1:0]     w_fifo_count;
    logic                w_overflow;
    logic                w_frame_err;
    logic [14*c_HIST-1:0] w_hex;
`ifdef PS2_ERR_KEEP_EN
    logic                w_rx_err;
`endif

    ps2_rx_fifo #(
        .FIFO_DEPTH     (c_FIFO_DEPTH),
        .FILTER_LEN     (c_FILTER_LEN),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .HIST           (c_HIST)
    ) dut (
        .CLOCK_50     (r_clk),
        .reset        (r_rst),
        .PS2_CLK      (w_ps2_clk),
        .PS2_DAT      (w_ps2_dat),
        .rx_data      (w_rx_data),
        .rx_valid     (w_rx_valid),
        .rx_ready     (r_rx_ready),
        .fifo_count   (w_fifo_count),
        .overflow     (w_overflow),
        .clr_overflow (r_clr_overflow),
        .frame_err    (w_frame_err),
`ifdef PS2_ERR_KEEP_EN
        .rx_err       (w_rx_err),
`endif
        .HEX          (w_hex)
    );

    always #5 r_clk = ~r_clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_ferr = 0;

    logic [8:0]        q [$];
    logic [7:0]        m_hist [c_HIST];
    logic [c_HIST-1:0] m_vld = '0;
    logic              m_ovf = 1'b0;

    always @(negedge r_clk) begin
        if (w_frame_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
        endcase
    endfunction

    function automatic logic [14*c_HIST-1:0] exp_hex();
        logic [14*c_HIST-1:0] h;
        for (int k = 0; k < c_HIST; k++) begin
            h[14*k +: 7]   = m_vld[k] ? seg(m_hist[k][3:0]) : 7'h7F;
            h[14*k+7 +: 7] = m_vld[k] ? seg(m_hist[k][7:4]) : 7'h7F;
        end
        return h;
    endfunction

    task automatic model_push(input logic [7:0] b, input logic good);
        logic keep;
`ifdef PS2_ERR_KEEP_EN
        keep = 1'b1;
`else
        keep = good;
`endif
        if (keep) begin
            if (q.size() < c_FIFO_DEPTH) begin
                q.push_back({!good, b});
                for (int k = c_HIST - 1; k > 0; k--) begin
                    m_hist[k] = m_hist[k-1];
                    m_vld[k]  = m_vld[k-1];
                end
                m_hist[0] = b;
                m_vld[0]  = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // bits[0] goes first; lat = cycles from the last bit's clock drop to rx_valid
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch, output int lat);
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            r_ps2_dat = bits[i];
            if (glitch) begin
                repeat (14) @(negedge r_clk);
                r_ps2_clk = 1'b0;
                repeat (3) @(negedge r_clk);
                r_ps2_clk = 1'b1;
                repeat (c_HALF_BIT - 17) @(negedge r_clk);
            end else begin
                repeat (c_HALF_BIT) @(negedge r_clk);
            end
            r_ps2_clk = 1'b0;
            for (int n = 1; n <= c_HALF_BIT; n++) begin
                @(negedge r_clk);
                if (glitch && n == 14) r_ps2_clk = 1'b1;
                if (glitch && n == 17) r_ps2_clk = 1'b0;
                if (i == nbits - 1 && lat == 0 && w_rx_valid) lat = n;
            end
            r_ps2_clk = 1'b1;
        end
        r_ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                              input bit glitch, output int lat);
        logic par;
        par = ~(^d) ^ par_flip;
        model_push(d, !par_flip && stop);
        send_bits({stop, par, d, 1'b0}, 11, glitch, lat);
    endtask

    task automatic drain();
        logic [8:0] exp;
        int guard;
        guard = 0;
        while (w_rx_valid && guard < c_FIFO_DEPTH + 4) begin
            guard++;
            chk("pop_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                exp = q.pop_front();
`ifdef PS2_ERR_KEEP_EN
                chk("rx_data", 32'({w_rx_err, w_rx_data}), 32'(exp));
`else
                chk("rx_data", 32'({1'b0, w_rx_data}), 32'(exp));
`endif
            end
            r_rx_ready = 1'b1;
            @(negedge r_clk);
            r_rx_ready = 1'b0;
        end
        chk("drain_valid", 32'(w_rx_valid), 0);
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int f0;

        repeat (5) @(negedge r_clk);
        r_rst = 1'b0;
        @(negedge r_clk);
        chk("rst_valid", 32'(w_rx_valid), 0);
        chk("rst_count", 32'(w_fifo_count), 0);
        chk("rst_ovf", 32'(w_overflow), 0);
        chk("rst_ferr", 32'(w_frame_err), 0);
        chk("rst_hex", 32'(w_hex), 32'h0FFF_FFFF);

        // Single good frame, latency and display
        send_frame(8'h1C, 0, 1'b1, 0, lat);
        chk("latency", lat, 2 + c_FILTER_LEN);
        chk("head_1C", 32'(w_rx_data), 32'h1C);
        chk("count_1", 32'(w_fifo_count), 1);
        chk("hex_lo_C", 32'(w_hex[6:0]), 32'b1000110);
        chk("hex_hi_1", 32'(w_hex[13:7]), 32'b1111001);
        chk("hex_model1", 32'(w_hex), 32'(exp_hex()));
        drain();

        // Two frames: history order and FIFO order
        send_frame(8'hF0, 0, 1'b1, 0, lat);
        send_frame(8'h1C, 0, 1'b1, 0, lat);
        chk("slot0_1C", 32'(w_hex[13:0]), 32'({seg(4'h1), seg(4'hC)}));
        chk("slot1_F0", 32'(w_hex[27:14]), 32'({seg(4'hF), seg(4'h0)}));
        chk("count_2", 32'(w_fifo_count), 2);
        drain();

        // Bad parity then bad stop
        f0 = n_ferr;
        send_frame(8'h1C, 1, 1'b1, 0, lat);
        repeat (2) @(negedge r_clk);
        chk("ferr_parity", n_ferr - f0, 1);
        chk("count_badpar", 32'(w_fifo_count), q.size());
        chk("hex_badpar", 32'(w_hex), 32'(exp_hex()));
        drain();
        f0 = n_ferr;
        send_frame(8'h3A, 0, 1'b0, 0, lat);
        repeat (2) @(negedge r_clk);
        chk("ferr_stop", n_ferr - f0, 1);
        chk("count_badstop", 32'(w_fifo_count), q.size());
        drain();

        // Overflow: one more frame than the FIFO holds
        for (int i = 1; i <= c_FIFO_DEPTH + 1; i++) begin
            send_frame(8'(i), 0, 1'b1, 0, lat);
        end
        chk("count_full", 32'(w_fifo_count), c_FIFO_DEPTH);
        chk("ovf_set", 32'(w_overflow), 1);
        chk("ovf_model", 32'(w_overflow), 32'(m_ovf));
        chk("head_byte1", 32'(w_rx_data), 32'h01);
        chk("hex_full", 32'(w_hex), 32'(exp_hex()));
        r_clr_overflow = 1'b1;
        @(negedge r_clk);
        r_clr_overflow = 1'b0;
        m_ovf = 1'b0;
        @(negedge r_clk);
        chk("ovf_clr", 32'(w_overflow), 0);
        drain();

        // Stall after four data bits, then a clean frame
        f0 = n_ferr;
        send_bits({2'b11, 8'hA5, 1'b0}, 5, 0, lat);
        repeat (c_TIMEOUT + 50) @(negedge r_clk);
        chk("ferr_timeout", n_ferr - f0, 1);
        chk("count_timeout", 32'(w_fifo_count), 0);
        send_frame(8'h29, 0, 1'b1, 0, lat);
        chk("count_29", 32'(w_fifo_count), 1);
        drain();

        // Short glitches on both clock phases
        f0 = n_ferr;
        send_frame(8'h5A, 0, 1'b1, 1, lat);
        chk("ferr_glitch", n_ferr - f0, 0);
        chk("hex_glitch", 32'(w_hex), 32'(exp_hex()));
        drain();

        // Reset part-way through a frame with data buffered
        send_frame(8'h33, 0, 1'b1, 0, lat);
        send_bits({2'b11, 8'h55, 1'b0}, 6, 0, lat);
        r_rst = 1'b1;
        repeat (3) @(negedge r_clk);
        r_rst = 1'b0;
        q.delete();
        m_vld = '0;
        @(negedge r_clk);
        chk("mrst_valid", 32'(w_rx_valid), 0);
        chk("mrst_count", 32'(w_fifo_count), 0);
        chk("mrst_ovf", 32'(w_overflow), 0);
        chk("mrst_ferr", 32'(w_frame_err), 0);
        chk("mrst_hex", 32'(w_hex), 32'h0FFF_FFFF);
        send_frame(8'h77, 0, 1'b1, 0, lat);
        chk("hex_77", 32'(w_hex), 32'(exp_hex()));
        chk("count_77", 32'(w_fifo_count), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
